// File: rtl/mvm_tile.sv
// Matrix-vector-multiply NoC endpoint: weight RFs, instruction loop, input/reduction
// vector FIFOs, DPES int8 dot-product engines and an AXI-Stream release path.
module mvm_tile #(
  parameter int DATAW          = 512,
  parameter int BYTEW          = 8,
  parameter int IDW            = 32,
  parameter int DESTW          = 12,
  parameter int USERW          = 75,
  parameter int IPRECISION     = 8,
  parameter int OPRECISION     = 32,
  parameter int LANES          = DATAW / IPRECISION,
  parameter int DPES           = 64,
  parameter int NODESW         = 9,
  parameter int RFDEPTH        = 512,
  parameter int RFADDRW        = 9,
  parameter int INSTW          = 32,
  parameter int INSTD          = 512,
  parameter int INSTADDRW      = 9,
  parameter int FIFOD          = 64,
  parameter int DATAPATH_DELAY = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 axis_rx_tvalid,
  input  logic [DATAW-1:0]     axis_rx_tdata,
  input  logic [BYTEW-1:0]     axis_rx_tstrb,
  input  logic [BYTEW-1:0]     axis_rx_tkeep,
  input  logic [IDW-1:0]       axis_rx_tid,
  input  logic [DESTW-1:0]     axis_rx_tdest,
  input  logic [USERW-1:0]     axis_rx_tuser,
  input  logic                 axis_rx_tlast,
  output logic                 axis_rx_tready,
  output logic                 axis_tx_tvalid,
  output logic [DATAW-1:0]     axis_tx_tdata,
  output logic [BYTEW-1:0]     axis_tx_tstrb,
  output logic [BYTEW-1:0]     axis_tx_tkeep,
  output logic [IDW-1:0]       axis_tx_tid,
  output logic [DESTW-1:0]     axis_tx_tdest,
  output logic [USERW-1:0]     axis_tx_tuser,
  output logic                 axis_tx_tlast,
  input  logic                 axis_tx_tready
);

  localparam int AW   = $clog2(FIFOD);
  localparam int CNTW = $clog2(FIFOD + 1);
  localparam int PKTW = DATAW + NODESW + 1;

  logic [1:0]           w_rxOp;
  logic [RFADDRW-1:0]   w_rxAddr;
  logic [DPES-1:0]      w_rxMask;
  logic                 w_rxFire;
  logic                 w_unused;

  logic [INSTW-1:0]     r_imem [INSTD];
  logic [INSTD-1:0]     r_instValid;
  logic [INSTADDRW-1:0] r_pc;
  logic [DATAW-1:0]     r_rf [DPES][RFDEPTH];
  logic [DPES*OPRECISION-1:0] r_acc [RFDEPTH];
  logic [RFDEPTH-1:0]   r_accValid;

  // Vector FIFOs: index 0 is the input FIFO, index 1 the reduction FIFO.
  logic [DATAW-1:0]     r_vMem [2][FIFOD];
  logic [AW-1:0]        r_vWr [2];
  logic [AW-1:0]        r_vRd [2];
  logic [CNTW-1:0]      r_vCnt [2];
  logic [1:0]           w_vPush, w_vPop, w_vEmpty, w_vFull;

  logic [PKTW-1:0]      r_oMem [FIFOD];
  logic [AW-1:0]        r_oWr, r_oRd;
  logic [CNTW-1:0]      r_oCnt;
  logic [PKTW-1:0]      w_oHead;
  logic                 w_txPop;

  logic [DATAPATH_DELAY-1:0] r_pipeValid;
  logic [PKTW-1:0]      r_pipeData [DATAPATH_DELAY];
  logic [CNTW-1:0]      r_inflight;
  logic                 w_pipeOut;

  logic [INSTW-1:0]     w_inst;
  logic                 w_instRdc, w_instAcm, w_instRls, w_instLst, w_instOp;
  logic [RFADDRW-1:0]   w_accAddr, w_rfAddr;
  logic [NODESW-1:0]    w_instDest;
  logic                 w_issue;
  logic [DATAW-1:0]     w_inVec, w_redVec, w_result;
  logic [DPES*OPRECISION-1:0] w_accRd, w_accNext;

  assign w_rxAddr = axis_rx_tuser[RFADDRW-1:0];
  assign w_rxOp   = axis_rx_tuser[RFADDRW+1:RFADDRW];
  assign w_rxMask = axis_rx_tuser[RFADDRW+2 +: DPES];
  assign w_rxFire = axis_rx_tvalid & axis_rx_tready;
  assign w_unused = ^{axis_rx_tstrb, axis_rx_tkeep, axis_rx_tid, axis_rx_tdest, axis_rx_tlast};

  always_comb begin
    for (int f = 0; f < 2; f++) begin
      w_vEmpty[f] = (r_vCnt[f] == '0);
      w_vFull[f]  = (r_vCnt[f] == CNTW'(FIFOD));
    end
    case (w_rxOp)
      2'b10:   axis_rx_tready = !w_vFull[0];
      2'b01:   axis_rx_tready = !w_vFull[1];
      default: axis_rx_tready = 1'b1;
    endcase
  end

  assign w_inst     = r_imem[r_pc];
  assign w_instRdc  = w_inst[0];
  assign w_instAcm  = w_inst[1];
  assign w_instRls  = w_inst[2];
  assign w_instLst  = w_inst[3];
  assign w_accAddr  = w_inst[4 +: RFADDRW];
  assign w_rfAddr   = w_inst[13 +: RFADDRW];
  assign w_instDest = w_inst[22 +: NODESW];
  assign w_instOp   = w_inst[31];

  // Reserve an output slot for every release still in the pipeline so results never drop.
  assign w_issue = r_instValid[r_pc] && !w_vEmpty[0] && (!w_instRdc || !w_vEmpty[1])
                   && ((CNTW'(FIFOD) - r_oCnt) > r_inflight);

  assign w_vPush  = {w_rxFire && (w_rxOp == 2'b01), w_rxFire && (w_rxOp == 2'b10)};
  assign w_vPop   = {w_issue & w_instRdc, w_issue};
  assign w_inVec  = r_vMem[0][r_vRd[0]];
  assign w_redVec = r_vMem[1][r_vRd[1]];
  assign w_accRd  = r_accValid[w_accAddr] ? r_acc[w_accAddr] : '0;

  always_comb begin : pDot
    logic signed [IPRECISION-1:0] a, b;
    logic signed [OPRECISION-1:0] sum;
    a = '0;
    b = '0;
    sum = '0;
    w_accNext = '0;
    w_result = '0;
    for (int i = 0; i < DPES; i++) begin
      sum = '0;
      for (int l = 0; l < LANES; l++) begin
        a = w_inVec[l*IPRECISION +: IPRECISION];
        b = r_rf[i][w_rfAddr][l*IPRECISION +: IPRECISION];
        sum = sum + OPRECISION'(a) * OPRECISION'(b);
      end
      if (w_instRdc) begin
        a = w_redVec[i*IPRECISION +: IPRECISION];
        sum = sum + OPRECISION'(a);
      end
      if (w_instAcm) sum = sum + w_accRd[i*OPRECISION +: OPRECISION];
      w_accNext[i*OPRECISION +: OPRECISION] = sum;
      w_result[i*IPRECISION +: IPRECISION] = sum[IPRECISION-1:0];
    end
  end

  assign w_pipeOut = r_pipeValid[DATAPATH_DELAY-1];
  assign w_oHead   = r_oMem[r_oRd];
  assign w_txPop   = axis_tx_tvalid & axis_tx_tready;

  // Control state; accumulators are updated at issue, so back-to-back hazards resolve in order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc        <= '0;
      r_instValid <= '0;
      r_accValid  <= '0;
      r_pipeValid <= '0;
      r_inflight  <= '0;
      r_oWr       <= '0;
      r_oRd       <= '0;
      r_oCnt      <= '0;
      for (int f = 0; f < 2; f++) begin
        r_vWr[f]  <= '0;
        r_vRd[f]  <= '0;
        r_vCnt[f] <= '0;
      end
    end else begin
      if (w_rxFire && w_rxOp == 2'b00) r_instValid[w_rxAddr] <= 1'b1;
      if (w_issue) begin
        r_pc <= w_instLst ? '0 : r_pc + 1'b1;
        r_accValid[w_accAddr] <= 1'b1;
      end
      r_pipeValid <= {r_pipeValid[DATAPATH_DELAY-2:0], w_issue & w_instRls};
      r_inflight  <= r_inflight + CNTW'(w_issue & w_instRls) - CNTW'(w_pipeOut);
      for (int f = 0; f < 2; f++) begin
        if (w_vPush[f]) r_vWr[f] <= r_vWr[f] + 1'b1;
        if (w_vPop[f])  r_vRd[f] <= r_vRd[f] + 1'b1;
        r_vCnt[f] <= r_vCnt[f] + CNTW'(w_vPush[f]) - CNTW'(w_vPop[f]);
      end
      if (w_pipeOut) r_oWr <= r_oWr + 1'b1;
      if (w_txPop)   r_oRd <= r_oRd + 1'b1;
      r_oCnt <= r_oCnt + CNTW'(w_pipeOut) - CNTW'(w_txPop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_rxFire && w_rxOp == 2'b00) r_imem[w_rxAddr] <= axis_rx_tdata[INSTW-1:0];
    if (w_rxFire && w_rxOp == 2'b11)
      for (int i = 0; i < DPES; i++)
        if (w_rxMask[i]) r_rf[i][w_rxAddr] <= axis_rx_tdata;
    for (int f = 0; f < 2; f++)
      if (w_vPush[f]) r_vMem[f][r_vWr[f]] <= axis_rx_tdata;
    if (w_issue) r_acc[w_accAddr] <= w_instRls ? '0 : w_accNext;
    r_pipeData[0] <= {w_instOp, w_instDest, w_result};
    for (int k = 1; k < DATAPATH_DELAY; k++) r_pipeData[k] <= r_pipeData[k-1];
    if (w_pipeOut) r_oMem[r_oWr] <= r_pipeData[DATAPATH_DELAY-1];
  end

  assign axis_tx_tvalid = (r_oCnt != '0);
  assign axis_tx_tdata  = w_oHead[DATAW-1:0];
  assign axis_tx_tdest  = {{(DESTW-NODESW){1'b0}}, w_oHead[DATAW +: NODESW]};
  assign axis_tx_tuser  = {{(USERW-RFADDRW-2){1'b0}}, (w_oHead[PKTW-1] ? 2'b01 : 2'b10),
                           {RFADDRW{1'b0}}};
  assign axis_tx_tstrb  = '1;
  assign axis_tx_tkeep  = '1;
  assign axis_tx_tid    = '0;
  assign axis_tx_tlast  = 1'b1;

endmodule

// File: tb/tb_mvm_tile.sv
// Directed self-checking bench for mvm_tile: RF/instruction loading, dot products,
// reduction, accumulation, release packets, backpressure and FIFO-full behaviour.
module tb_mvm_tile;

  // Clock and DUT signals
  logic           clk = 1'b0;
  logic           rst;
  logic           axis_rx_tvalid;
  logic [511:0]   axis_rx_tdata;
  logic [7:0]     axis_rx_tstrb;
  logic [7:0]     axis_rx_tkeep;
  logic [31:0]    axis_rx_tid;
  logic [11:0]    axis_rx_tdest;
  logic [74:0]    axis_rx_tuser;
  logic           axis_rx_tlast;
  logic           axis_rx_tready;
  logic           axis_tx_tvalid;
  logic [511:0]   axis_tx_tdata;
  logic [7:0]     axis_tx_tstrb;
  logic [7:0]     axis_tx_tkeep;
  logic [31:0]    axis_tx_tid;
  logic [11:0]    axis_tx_tdest;
  logic [74:0]    axis_tx_tuser;
  logic           axis_tx_tlast;
  logic           axis_tx_tready;

  int errors = 0;
  int checks = 0;
  logic [511:0] expVec;

  always #5 clk = ~clk;

  mvm_tile dut (
    .clk(clk), .rst(rst),
    .axis_rx_tvalid(axis_rx_tvalid), .axis_rx_tdata(axis_rx_tdata),
    .axis_rx_tstrb(axis_rx_tstrb), .axis_rx_tkeep(axis_rx_tkeep),
    .axis_rx_tid(axis_rx_tid), .axis_rx_tdest(axis_rx_tdest),
    .axis_rx_tuser(axis_rx_tuser), .axis_rx_tlast(axis_rx_tlast),
    .axis_rx_tready(axis_rx_tready),
    .axis_tx_tvalid(axis_tx_tvalid), .axis_tx_tdata(axis_tx_tdata),
    .axis_tx_tstrb(axis_tx_tstrb), .axis_tx_tkeep(axis_tx_tkeep),
    .axis_tx_tid(axis_tx_tid), .axis_tx_tdest(axis_tx_tdest),
    .axis_tx_tuser(axis_tx_tuser), .axis_tx_tlast(axis_tx_tlast),
    .axis_tx_tready(axis_tx_tready)
  );

  // Replicate one byte across all 64 lanes
  function automatic logic [511:0] fillLanes(input logic [7:0] b);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = b;
    return r;
  endfunction

  // One comparison point: count it, and on mismatch count and report the failure
  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one rx beat starting at a negedge and hold it until accepted (bounded)
  task automatic applyStimulus(input logic [1:0] op, input logic [8:0] addr,
                               input logic [63:0] mask, input logic [511:0] data);
    int n;
    axis_rx_tdata  = data;
    axis_rx_tuser  = {mask, op, addr};
    axis_rx_tvalid = 1'b1;
    #1;
    n = 0;
    while (!axis_rx_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rx_accept", axis_rx_tready, 1);
    @(negedge clk);
    axis_rx_tvalid = 1'b0;
  endtask

  // Wait a bounded number of cycles for a tx packet to appear
  task automatic waitTx(input string tag);
    int n;
    n = 0;
    while (!axis_tx_tvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, axis_tx_tvalid, 1);
  endtask

  // Take exactly one tx transfer
  task automatic popTx();
    axis_tx_tready = 1'b1;
    @(negedge clk);
    axis_tx_tready = 1'b0;
  endtask

  // Hard stop if something wedges beyond all bounded waits
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence
  initial begin
    rst = 1'b0;
    axis_rx_tvalid = 1'b0;
    axis_rx_tdata  = '0;
    axis_rx_tstrb  = '0;
    axis_rx_tkeep  = '0;
    axis_rx_tid    = '0;
    axis_rx_tdest  = '0;
    axis_rx_tuser  = '0;
    axis_rx_tlast  = 1'b0;
    axis_tx_tready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tvalid", axis_tx_tvalid, 0);
    checkOutput("reset_rx_ready_op0", axis_rx_tready, 1);
    rst = 1'b1;
    @(negedge clk);

    // Scenario 1: weights 1, input 1, acm from an unwritten accumulator -> 0x40 lanes
    applyStimulus(2'b11, 9'd1, {64{1'b1}}, fillLanes(8'h01));
    applyStimulus(2'b00, 9'd0, 64'd0, {480'd0, 32'h8000_200E});
    applyStimulus(2'b10, 9'd0, 64'd0, fillLanes(8'h01));
    waitTx("s1_tvalid");
    checkOutput("s1_tdata", axis_tx_tdata, fillLanes(8'h40));
    checkOutput("s1_tuser", axis_tx_tuser, 75'h200);
    checkOutput("s1_tdest", axis_tx_tdest, 12'h000);
    checkOutput("s1_tlast_keep_strb", {axis_tx_tlast, axis_tx_tkeep, axis_tx_tstrb}, 17'h1FFFF);
    checkOutput("s1_tid", axis_tx_tid, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("bp_tvalid_held", axis_tx_tvalid, 1);
    checkOutput("bp_tdata_held", axis_tx_tdata, fillLanes(8'h40));
    popTx();
    checkOutput("bp_single_transfer", axis_tx_tvalid, 0);

    // Scenario 2: reduction vector 0x02 adds per lane -> 0x42
    applyStimulus(2'b00, 9'd0, 64'd0, {480'd0, 32'h8000_200F});
    applyStimulus(2'b01, 9'd0, 64'd0, fillLanes(8'h02));
    applyStimulus(2'b10, 9'd0, 64'd0, fillLanes(8'h01));
    waitTx("s2_tvalid");
    checkOutput("s2_tdata", axis_tx_tdata, fillLanes(8'h42));
    popTx();
    // Reduction FIFO must now be empty, so an rdc instruction stalls on input alone
    applyStimulus(2'b10, 9'd0, 64'd0, fillLanes(8'h01));
    repeat (30) @(negedge clk);
    checkOutput("s2_red_empty_stall", axis_tx_tvalid, 0);
    applyStimulus(2'b01, 9'd0, 64'd0, fillLanes(8'h02));
    waitTx("s2b_tvalid");
    checkOutput("s2b_tdata", axis_tx_tdata, fillLanes(8'h42));
    popTx();

    // Scenario 3: accumulate into addr 3 then release -> 0x80, single packet
    applyStimulus(2'b00, 9'd1, 64'd0, {480'd0, 32'h8000_203E});
    applyStimulus(2'b00, 9'd0, 64'd0, {480'd0, 32'h0000_2032});
    applyStimulus(2'b10, 9'd0, 64'd0, fillLanes(8'h01));
    applyStimulus(2'b10, 9'd0, 64'd0, fillLanes(8'h01));
    waitTx("s3_tvalid");
    checkOutput("s3_tdata", axis_tx_tdata, fillLanes(8'h80));
    checkOutput("s3_tuser", axis_tx_tuser, 75'h200);
    popTx();
    repeat (20) @(negedge clk);
    checkOutput("s3_single_packet", axis_tx_tvalid, 0);
    // Release cleared accum 3; rls_op=0 and dest 5 exercise the other header encoding
    applyStimulus(2'b00, 9'd0, 64'd0, {480'd0, 32'h0140_203E});
    applyStimulus(2'b10, 9'd0, 64'd0, fillLanes(8'h01));
    waitTx("s3b_tvalid");
    checkOutput("s3b_tdata_acc_cleared", axis_tx_tdata, fillLanes(8'h40));
    checkOutput("s3b_tuser", axis_tx_tuser, 75'h400);
    checkOutput("s3b_tdest", axis_tx_tdest, 12'h005);
    popTx();

    // Scenario 4: reset, then fill the input FIFO with no valid instructions
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("s4_reset_tvalid", axis_tx_tvalid, 0);
    for (int k = 0; k < 64; k++) applyStimulus(2'b10, 9'd0, 64'd0, fillLanes(8'h01));
    axis_rx_tuser = {64'd0, 2'b10, 9'd0};
    #1;
    checkOutput("s4_in_full_not_ready", axis_rx_tready, 0);
    axis_rx_tuser = {64'd0, 2'b01, 9'd0};
    #1;
    checkOutput("s4_red_still_ready", axis_rx_tready, 1);
    @(negedge clk);

    // Scenario 5: mask selects DPE 5 only, weights 0xFF -> lane 5 = -64, others keep 0x40
    applyStimulus(2'b11, 9'd1, 64'd1 << 5, fillLanes(8'hFF));
    applyStimulus(2'b00, 9'd0, 64'd0, {480'd0, 32'h8000_200C});
    expVec = fillLanes(8'h40);
    expVec[5*8 +: 8] = 8'hC0;
    waitTx("s5_tvalid");
    checkOutput("s5_tdata", axis_tx_tdata, expVec);
    popTx();
    waitTx("s5b_tvalid");
    checkOutput("s5b_tdata", axis_tx_tdata, expVec);
    popTx();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mvm_tile.md
Name: mvm_tile

Overview:
- Matrix-vector-multiply NoC endpoint with AXI-Stream rx/tx.
- Holds one weight register file (RF) per dot-product engine (DPE), an instruction memory, and input/reduction vector FIFOs.
- Executes a looping instruction program. Each instruction computes DPES int8 dot products, with optional reduction add and accumulation, and optionally releases the result as a 512-bit packet to another NoC node.

Parameters:
DATAW 512 stream data width
BYTEW 8 tstrb/tkeep width
IDW 32 tid width
DESTW 12 tdest width
USERW 75 tuser width
IPRECISION 8 input/weight/output lane width (signed)
OPRECISION 32 internal accumulator width
LANES 64 DATAW/IPRECISION
DPES 64 number of DPEs (one output lane each)
NODES 512; NODESW 9 destination node space
RFDEPTH 512; RFADDRW 9 RF and accumulator depth
INSTW 32 instruction width
INSTD 512; INSTADDRW 9 instruction memory depth
AXIS_OPS 4; AXIS_OPSW 2 rx opcode space
FIFOD 64 depth of input, reduction and output FIFOs
DATAPATH_DELAY 12 issue-to-result latency in cycles

Ports:
clk in 1 clock
rst in 1 synchronous active-low reset
axis_rx_tvalid in 1; axis_rx_tdata in DATAW; axis_rx_tstrb in BYTEW; axis_rx_tkeep in BYTEW; axis_rx_tid in IDW; axis_rx_tdest in DESTW; axis_rx_tuser in USERW; axis_rx_tlast in 1; axis_rx_tready out 1
axis_tx_tvalid out 1; axis_tx_tdata out DATAW; axis_tx_tstrb out BYTEW; axis_tx_tkeep out BYTEW; axis_tx_tid out IDW; axis_tx_tdest out DESTW; axis_tx_tuser out USERW; axis_tx_tlast out 1; axis_tx_tready in 1

Behaviour:
- One clock (clk). rst is synchronous and active-low.
- Reset state:
  - all FIFOs empty; PC=0
  - instruction valid bits cleared; accumulators read as 0
  - pipeline valid bits cleared; axis_tx_tvalid=0
  - RF contents not reset
- rx accept: transfer = tvalid&tready. tuser[10:9]=op, tuser[8:0]=addr, tuser[74:11]=DPE mask. tstrb/tkeep/tid/tdest/tlast ignored.
  - op 11: for each i with mask[i]=1, RF_i[addr] <= tdata. tready=1.
  - op 10: push tdata to input FIFO. tready=!full.
  - op 01: push tdata to reduction FIFO. tready=!full.
  - op 00: IMEM[addr] <= tdata[31:0], set valid[addr]. tready=1.
- Instruction fields:
  - bit0 rdc
  - bit1 acm_en
  - bit2 rls
  - bit3 lst
  - [12:4] accum_addr
  - [21:13] rf_addr
  - [30:22] rls_dest
  - [31] rls_op
- Issue, at most one instruction per cycle, when all hold:
  - valid[PC]
  - input FIFO non-empty
  - (!rdc or reduction FIFO non-empty)
  - output FIFO free slots > in-flight releases
- On issue:
  - pop input FIFO; pop reduction FIFO if rdc
  - PC <= lst ? 0 : PC+1, wrapping at INSTD-1
- Datapath, per DPE i:
  - dot_i = sum over lanes l of signed(in[l]) * signed(RF_i[rf_addr][l]), at OPRECISION bits
  - r_i = dot_i + (rdc ? signed(red[i]) : 0) + (acm_en ? acc_i[accum_addr] : 0)
  - if rls: result lane i = r_i[7:0] (truncation), and acc_i[accum_addr] <= 0
  - else: acc_i[accum_addr] <= r_i
  - Result is valid exactly DATAPATH_DELAY cycles after issue.
  - Accumulator read/write hazards on the same accum_addr in back-to-back instructions must be forwarded (result equals sequential execution).
- Release packet, pushed to output FIFO:
  - tdata lane i = result_i
  - tdest = {3'b0, rls_dest}
  - tuser[10:9] = rls_op ? 2'b01 : 2'b10; tuser[8:0] = 0; tuser[74:11] = 0
- tx side:
  - tvalid = output FIFO non-empty; pop on tvalid&tready
  - packet held stable while tready=0
  - tlast=1, tstrb/tkeep all ones, tid=0
- Simultaneous rx push and issue pop on the same FIFO are both honoured.
- Reset mid-operation discards in-flight results.

Test Plan:
- RF write: op 11, addr 1, mask all ones, data all 0x01; input all 0x01; instr at 0 {rdc=0, acm=1, rls=1, lst=1, rf_addr=1, dest=0, rls_op=1} -> after ~DATAPATH_DELAY+few cycles tx tdata = 64 lanes of 0x40, tuser[10:9]=01, tdest=0.
- Same as the first scenario but rdc=1 with reduction vector all 0x02 -> lanes 0x42; reduction FIFO empty afterwards.
- Two instructions: first {acm, rls=0, accum 3}, then {acm, rls=1, lst, accum 3}, two input vectors all 0x01 -> one packet, lanes 0x80; then accum 3 reads 0.
- Output backpressure: tx_tready=0 -> packet held, tvalid stays 1, no loss. Then tready=1 -> exactly one transfer.
- Fill input FIFO with FIFOD vectors and no instructions -> rx_tready=0 for op 10 while op 11 is still accepted.
- Mask selecting only DPE 5, weights 0xFF, input 0x01 -> lane 5 = 0xC0 (-64), other lanes = the previously stored RF dot product.
